fifo_wr_adapter: RTL and testbench
==================================

// Module: fifo_wr_adapter
//
// PURPOSE
//   Write-side counterpart of the FWFT read adapter: converts an upstream valid/ready stream into a standard FIFO write port.
//   Sits between a producer (stream source) and the write side of a native FIFO that exposes full/almost_full.
//   FIFO-side outputs are fully registered for timing closure.
//   A 2-entry skid buffer absorbs beats already accepted when the FIFO stalls, giving full throughput and no overflow.
//
// PARAMETERS
//   DATA_WIDTH  8  width of s_data / fifo_din in bits; must be >= 1
//
// PORTS
//   clk              in   1           single clock; all logic on posedge
//   resetn           in   1           asynchronous active-low reset
//   s_valid          in   1           upstream beat present
//   s_data           in   DATA_WIDTH  upstream beat payload
//   s_ready          out  1           adapter can accept a beat (registered)
//   fifo_full        in   1           FIFO full; updates the cycle after the write that fills it
//   fifo_almost_full in   1           FIFO has exactly one free slot (or fewer)
//   fifo_wr_en       out  1           FIFO write strobe (registered)
//   fifo_din         out  DATA_WIDTH  FIFO write data (registered)
//   overflow         out  1           sticky: fifo_wr_en was high while fifo_full was high
//
// BEHAVIOUR
//   - Reset (resetn=0, async): s_ready=0, fifo_wr_en=0, fifo_din=0, overflow=0, skid count=0, skid entries=0.
//     s_ready rises on the first clk edge after resetn deasserts.
//     Reset mid-operation discards any skid contents and any pending write.
//   - Accept: a beat transfers when s_valid && s_ready at a posedge. s_valid is not qualified by s_ready (AXI-stream rules).
//   - can_wr = !fifo_full && !(fifo_wr_en && fifo_almost_full).
//     Meaning: the FIFO has a free slot for a write issued next cycle, accounting for the write currently on the port.
//   - Source priority each cycle: skid head (oldest) first, then the incoming accepted beat. Strict FIFO ordering.
//   - If can_wr and a source exists: fifo_wr_en<=1 and fifo_din<=source. Otherwise fifo_wr_en<=0 and fifo_din holds.
//   - Skid update, with cnt in {0,1,2}:
//       cnt=0, accept, can_wr   -> bypass to output; cnt stays 0
//       cnt=0, accept, !can_wr  -> push; cnt=1
//       cnt=1, accept, can_wr   -> pop head to output, push input; cnt=1
//       cnt=1, accept, !can_wr  -> push; cnt=2
//       cnt>0, no accept, can_wr -> pop; cnt-1
//       cnt=2: no accept is possible, because s_ready=0
//   - s_ready <= (cnt_next != 2). Sustains 1 beat/cycle while can_wr=1.
//   - Latency: accepted beat with cnt=0 and can_wr appears on fifo_wr_en/fifo_din 1 cycle later.
//   - overflow <= overflow | (fifo_wr_en & fifo_full). Cleared only by reset; must never set in correct use.
//   - Widths: cnt is 2 bits. No arithmetic on data. The skid is two DATA_WIDTH registers plus head select; no wrap pointer.
//
// STRUCTURE
//   - fifo_adapter_defs.vh (shared with the FWFT read adapter): SKID_DEPTH=2, SKID_CNT_W=2.
//   - Sub-module fifo_skid_buf: 2-entry ordered buffer.
//       Ports: push, pop, din, head, cnt.
//       Supports push and pop in the same cycle.
//   - The top level holds the can_wr logic, the output register, s_ready and overflow.
//
// TESTING
//   - Reset: resetn=0 mid-stream with cnt=2 -> all outputs 0 immediately.
//     Then release resetn -> s_ready=1 one edge later and no stale write.
//   - Streaming: FIFO never full, 16 beats 0x00..0x0F back-to-back.
//     Required: fifo_wr_en high 16 consecutive cycles, each beat one cycle after acceptance, in order.
//   - Almost-full: fifo_almost_full=1 while a write is on the port.
//     Required: next cycle fifo_wr_en=0; beat 0x21 lands in the skid; cnt=1.
//   - Full stall: fifo_full=1 for 5 cycles while s_valid=1 (beats 0xA0..).
//     Required: 0xA0 and 0xA1 are skidded and s_ready=0.
//     Then deassert full -> 0xA0, 0xA1, 0xA2 written in order, with no gap after s_ready re-rises.
//   - Random check: random s_valid and random fifo_full/almost_full from a FIFO model, depth 4, 1000 beats.
//     Required: scoreboard matches, overflow stays 0, s_ready never drops with cnt<2.

Source files
------------

// File: rtl/fifo_wr_adapter_pkg.sv
// Shared constants for the FIFO write adapter and its skid buffer.
package fifo_wr_adapter_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  // Occupancy at which the skid can take no further beats.
  localparam logic [SKID_CNT_W-1:0] SKID_FULL_CNT = SKID_CNT_W'(SKID_DEPTH);

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry ordered buffer; the head is always entry 0, so no wrap pointer is needed.
module fifo_skid_buf
  import fifo_wr_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic [SKID_CNT_W-1:0] cnt
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;

  assign head = entry0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) entry0 <= din;
          else           entry1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push keeps occupancy; shift only when a second entry exists.
          if (cnt == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_adapter.sv
// Converts a valid/ready stream into a registered native FIFO write port.
// A 2-entry skid holds beats accepted while the FIFO cannot take a write.
module fifo_wr_adapter
  import fifo_wr_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  overflow
);

  logic                  accept;
  logic                  can_wr;
  logic                  have_skid;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [DATA_WIDTH-1:0] src;
  logic [SKID_CNT_W-1:0] skid_cnt;
  logic [SKID_CNT_W-1:0] cnt_next;

  assign accept    = s_valid && s_ready;
  // The write already on the port may consume the last free slot.
  assign can_wr    = !fifo_full && !(fifo_wr_en && fifo_almost_full);
  assign have_skid = (skid_cnt != '0);
  assign pop       = can_wr && have_skid;
  assign push      = accept && (have_skid || !can_wr);
  assign src       = have_skid ? skid_head : s_data;

  always_comb begin
    cnt_next = skid_cnt;
    case ({push, pop})
      2'b10:   cnt_next = skid_cnt + 2'd1;
      2'b01:   cnt_next = skid_cnt - 2'd1;
      default: cnt_next = skid_cnt;
    endcase
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (s_data),
    .head   (skid_head),
    .cnt    (skid_cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_ready    <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      overflow   <= 1'b0;
    end else begin
      s_ready  <= (cnt_next != SKID_FULL_CNT);
      overflow <= overflow | (fifo_wr_en & fifo_full);
      if (can_wr && (have_skid || accept)) begin
        fifo_wr_en <= 1'b1;
        fifo_din   <= src;
      end else begin
        fifo_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed and randomised checks of fifo_wr_adapter against a depth-4 FIFO occupancy model.
module tb_fifo_wr_adapter;

  localparam int DW = 8;

  logic          clk;
  logic          resetn;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          overflow;

  logic          full_drv;
  logic          af_drv;
  logic          model_en;
  int            occ;

  logic [DW-1:0] exp_q[$];
  int            n_checks;
  int            n_pass;

  fifo_wr_adapter #(.DATA_WIDTH(DW)) u_dut (
    .clk              (clk),
    .resetn           (resetn),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_din         (fifo_din),
    .overflow         (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_full        = model_en ? (occ >= 4) : full_drv;
  assign fifo_almost_full = model_en ? (occ >= 3) : af_drv;

  // depth-4 FIFO occupancy model with a random reader
  always @(posedge clk or negedge resetn) begin
    if (!resetn) occ <= 0;
    else occ <= occ + (fifo_wr_en ? 1 : 0) - (((occ > 0) && ($urandom_range(0, 1) == 1)) ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // scoreboard: record accepted beats, compare every FIFO write in order
  always @(negedge clk) begin
    if (resetn) begin
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) check("sb_unexpected_write", {24'd0, fifo_din}, 32'hFFFF_FFFF);
        else check("sb_data", {24'd0, fifo_din}, {24'd0, exp_q.pop_front()});
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  initial begin
    int beats;
    int cyc;
    int viol;
    logic acc;
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    full_drv = 1'b0;
    af_drv   = 1'b0;
    model_en = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);
    check("rst_overflow", overflow, 0);
    check("rst_cnt", u_dut.skid_cnt, 0);
    resetn = 1'b1;
    check("rdy_before_edge", s_ready, 0);
    tick();
    check("rdy_after_edge", s_ready, 1);

    // back-to-back streaming, one cycle latency
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1;
      s_data  = DW'(k);
      tick();
      check("stream_wr_en", fifo_wr_en, 1);
      check("stream_din", fifo_din, k);
      check("stream_ready", s_ready, 1);
    end
    s_valid = 1'b0;
    tick();
    check("stream_end_wr_en", fifo_wr_en, 0);

    // almost-full with a write on the port
    s_valid = 1'b1;
    s_data  = 8'h20;
    tick();
    check("af_first_wr", fifo_wr_en, 1);
    check("af_first_din", fifo_din, 8'h20);
    af_drv = 1'b1;
    s_data = 8'h21;
    tick();
    s_valid = 1'b0;
    check("af_wr_blocked", fifo_wr_en, 0);
    check("af_cnt", u_dut.skid_cnt, 1);
    check("af_din_hold", fifo_din, 8'h20);
    check("af_ready", s_ready, 1);
    tick();
    af_drv = 1'b0;
    check("af_drain_wr", fifo_wr_en, 1);
    check("af_drain_din", fifo_din, 8'h21);
    check("af_drain_cnt", u_dut.skid_cnt, 0);
    tick();
    check("af_idle", fifo_wr_en, 0);

    // full stall for 5 cycles
    full_drv = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'hA0;
    tick();
    s_data = 8'hA1;
    tick();
    s_data = 8'hA2;
    check("stall_ready", s_ready, 0);
    check("stall_cnt", u_dut.skid_cnt, 2);
    check("stall_wr_en", fifo_wr_en, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold_ready", s_ready, 0);
      check("stall_hold_wr_en", fifo_wr_en, 0);
    end
    full_drv = 1'b0;
    tick();
    check("unstall_wr0", fifo_wr_en, 1);
    check("unstall_din0", fifo_din, 8'hA0);
    check("unstall_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    check("unstall_wr1", fifo_wr_en, 1);
    check("unstall_din1", fifo_din, 8'hA1);
    tick();
    check("unstall_wr2", fifo_wr_en, 1);
    check("unstall_din2", fifo_din, 8'hA2);
    tick();
    check("unstall_idle", fifo_wr_en, 0);
    check("stall_overflow", overflow, 0);

    // reset with a full skid
    full_drv = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'hB0;
    tick();
    s_data = 8'hB1;
    tick();
    s_data = 8'hB2;
    check("pre_rst_cnt", u_dut.skid_cnt, 2);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_wr_en", fifo_wr_en, 0);
    check("mid_rst_din", fifo_din, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_cnt", u_dut.skid_cnt, 0);
    s_valid  = 1'b0;
    full_drv = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    check("rerst_rdy_before", s_ready, 0);
    tick();
    check("rerst_rdy_after", s_ready, 1);
    check("rerst_no_stale0", fifo_wr_en, 0);
    tick();
    check("rerst_no_stale1", fifo_wr_en, 0);

    // random traffic against the FIFO model
    model_en = 1'b1;
    beats = 0;
    cyc   = 0;
    viol  = 0;
    while (beats < 1000 && cyc < 20000) begin
      if (!s_valid) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = DW'($urandom_range(0, 255));
      end
      acc = s_valid && s_ready;
      tick();
      cyc++;
      if (acc) begin
        beats++;
        s_valid = 1'b0;
      end
      if (s_ready != (u_dut.skid_cnt != 2'd2)) viol++;
    end
    s_valid = 1'b0;
    check("rand_beats", beats, 1000);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    check("rand_drain", exp_q.size(), 0);
    check("rand_overflow", overflow, 0);
    check("rand_ready_vs_cnt", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
